// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined multiplier.
package mult_pkg;

  // Widest operand the entry conversion helper handles.
  localparam int MAX_W = 64;

  // Per-stage control record carried alongside each operation.
  // The valid bit lives in its own shift register (vld_pipe).
  typedef struct packed {
    logic sign;       // msb(mcand) ^ msb(mplier) at entry
    logic is_signed;  // operation was issued in two's-complement mode
  } stage_ctl_t;

  // Bits of the multiplier consumed per pipeline stage.
  function automatic int chunk_of(input int width, input int stages);
    return width / stages;
  endfunction

  // Magnitude of an operand. The caller passes the operand zero-extended and
  // 'neg' set when it is a negative signed value. Truncating the result back
  // to the operand width gives the unsigned magnitude, so the most negative
  // value maps to 2^(w-1), which still fits.
  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiplier pipeline stage: adds CHUNK shifted partial products of the
// multiplicand into the running sum, then registers the record under the
// global enable.
module mult_stage import mult_pkg::*; #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4,
  parameter int IDX    = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               d_vld,
  input  stage_ctl_t         d_ctl,
  input  logic [TAG_W-1:0]   d_tag,
  input  logic [WIDTH-1:0]   d_mc,
  input  logic [WIDTH-1:0]   d_mp,
  input  logic [2*WIDTH-1:0] d_acc,
  output logic               q_vld,
  output stage_ctl_t         q_ctl,
  output logic [TAG_W-1:0]   q_tag,
  output logic [WIDTH-1:0]   q_mc,
  output logic [WIDTH-1:0]   q_mp,
  output logic [2*WIDTH-1:0] q_acc
);

  localparam int CHUNK = chunk_of(WIDTH, STAGES);
  localparam int SHIFT = IDX * CHUNK;

  logic [2*WIDTH-1:0] sum;

  // Shift-add of mcand by the low CHUNK bits of the remaining multiplier,
  // weighted by this stage's position in the original multiplier.
  always_comb begin
    sum = d_acc;
    for (int j = 0; j < CHUNK; j++)
      if (d_mp[j]) sum = sum + ({{WIDTH{1'b0}}, d_mc} << (SHIFT + j));
  end

  // Stage register: cleared on reset, holds while the output is stalled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q_vld <= 1'b0;
      q_ctl <= '0;
      q_tag <= '0;
      q_mc  <= '0;
      q_mp  <= '0;
      q_acc <= '0;
    end else if (en) begin
      q_vld <= d_vld;
      q_ctl <= d_ctl;
      q_tag <= d_tag;
      q_mc  <= d_mc;
      q_mp  <= d_mp >> CHUNK;
      q_acc <= sum;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Fully pipelined WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned per
// operation, one op per cycle, valid/ready on both sides, in-order tags.
module mult_pipe import mult_pkg::*; #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic               is_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag
);

  if (WIDTH % STAGES != 0) begin : g_chk_div
    $error("mult_pipe: WIDTH must be a multiple of STAGES");
  end
  if (WIDTH > MAX_W) begin : g_chk_w
    $error("mult_pipe: WIDTH exceeds MAX_W");
  end

  // Index 0 is the converted entry record, index k the output of stage k-1.
  logic [STAGES:0]                vld_pipe;
  stage_ctl_t [STAGES:0]          ctl_pipe;
  logic [STAGES:0][TAG_W-1:0]     tag_pipe;
  logic [STAGES:0][WIDTH-1:0]     mc_pipe;
  logic [STAGES:0][WIDTH-1:0]     mp_pipe;
  logic [STAGES:0][2*WIDTH-1:0]   acc_pipe;

  logic stall, en, neg;

  // A held result freezes every stage; bubbles advance like real ops.
  assign out_valid = vld_pipe[STAGES];
  assign stall     = out_valid & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = en;

  // Entry: signed operands become magnitudes; the result sign is fixed up at the end.
  assign vld_pipe[0] = in_valid;
  assign ctl_pipe[0] = '{sign: mcand[WIDTH-1] ^ mplier[WIDTH-1], is_signed: is_signed};
  assign tag_pipe[0] = in_tag;
  assign mc_pipe[0]  = WIDTH'(abs_val(MAX_W'(mcand),  is_signed & mcand[WIDTH-1]));
  assign mp_pipe[0]  = WIDTH'(abs_val(MAX_W'(mplier), is_signed & mplier[WIDTH-1]));
  assign acc_pipe[0] = '0;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    mult_stage #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W), .IDX(i)) u_stage (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .d_vld (vld_pipe[i]),
      .d_ctl (ctl_pipe[i]),
      .d_tag (tag_pipe[i]),
      .d_mc  (mc_pipe[i]),
      .d_mp  (mp_pipe[i]),
      .d_acc (acc_pipe[i]),
      .q_vld (vld_pipe[i+1]),
      .q_ctl (ctl_pipe[i+1]),
      .q_tag (tag_pipe[i+1]),
      .q_mc  (mc_pipe[i+1]),
      .q_mp  (mp_pipe[i+1]),
      .q_acc (acc_pipe[i+1])
    );
  end

  // Final sign fix: negating a zero magnitude yields zero, so no -0 case.
  assign neg     = ctl_pipe[STAGES].sign & ctl_pipe[STAGES].is_signed;
  assign product = neg ? -acc_pipe[STAGES] : acc_pipe[STAGES];
  assign out_tag = tag_pipe[STAGES];

  // The last stage's multiplicand and exhausted multiplier are not needed.
  logic unused_tail;
  assign unused_tail = ^{mc_pipe[STAGES], mp_pipe[STAGES]};

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: default 64/8 instance with directed vectors,
// backpressure and reset, plus 32/4 and 16/16 instances with random ops.
module tb_mult_pipe;

  typedef struct {
    logic [127:0] p;
    logic [3:0]   t;
    int           c;
    bit           lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- default instance ----------------
  logic          in_valid = 1'b0, in_ready, is_signed = 1'b0, out_valid, out_ready = 1'b1;
  logic [63:0]   mcand = '0, mplier = '0;
  logic [3:0]    in_tag = '0, out_tag;
  logic [127:0]  product;
  exp_t          q[$];
  int            st_lo = 0, st_hi = 0;

  mult_pipe #(.WIDTH(64), .STAGES(8), .TAG_W(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mcand(mcand), .mplier(mplier), .is_signed(is_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .out_tag(out_tag)
  );

  // ---------------- 32/4 instance ----------------
  logic          v32 = 1'b0, r32, s32 = 1'b0, ov32;
  logic [31:0]   a32 = '0, b32 = '0;
  logic [3:0]    t32 = '0, ot32;
  logic [63:0]   p32;
  exp_t          q32[$];
  bit            done32 = 1'b0;

  mult_pipe #(.WIDTH(32), .STAGES(4), .TAG_W(4)) dut32 (
    .clock(clock), .reset(reset), .in_valid(v32), .in_ready(r32),
    .mcand(a32), .mplier(b32), .is_signed(s32), .in_tag(t32),
    .out_valid(ov32), .out_ready(1'b1), .product(p32), .out_tag(ot32)
  );

  // ---------------- 16/16 instance ----------------
  logic          v16 = 1'b0, r16, s16 = 1'b0, ov16;
  logic [15:0]   a16 = '0, b16 = '0;
  logic [3:0]    t16 = '0, ot16;
  logic [31:0]   p16;
  exp_t          q16[$];
  bit            done16 = 1'b0;

  mult_pipe #(.WIDTH(16), .STAGES(16), .TAG_W(4)) dut16 (
    .clock(clock), .reset(reset), .in_valid(v16), .in_ready(r16),
    .mcand(a16), .mplier(b16), .is_signed(s16), .in_tag(t16),
    .out_valid(ov16), .out_ready(1'b1), .product(p16), .out_tag(ot16)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference product: sign-extend w-bit operands to 128 bits, keep 2w bits.
  function automatic logic [127:0] mref(input logic [63:0] a, input logic [63:0] b,
                                        input int w, input logic s);
    logic [127:0] ea, eb, p;
    ea = {64'b0, a};
    eb = {64'b0, b};
    for (int i = w; i < 128; i++) begin
      ea[i] = s & a[w-1];
      eb[i] = s & b[w-1];
    end
    p = ea * eb;
    for (int i = 2 * w; i < 128; i++) p[i] = 1'b0;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    out_ready = !(cyc >= st_lo && cyc < st_hi);
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic s,
                      input logic [3:0] t, input logic [127:0] p, input bit lat);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    in_valid = 1'b1; mcand = a; mplier = b; is_signed = s; in_tag = t;
    do begin
      @(negedge clock);
      acc = in_ready;
      if (acc) q.push_back('{p, t, cyc, lat});
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) chk("send_timeout", 128'(acc), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 100) begin
      tick();
      g++;
    end
    chk("drain_left", 128'(q.size()), 128'(0));
  endtask

  // Main monitor: pops on transfer, checks stall stability and in_ready.
  logic         prev_stall = 1'b0;
  logic [127:0] pp = '0;
  logic [3:0]   pt = '0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (prev_stall) begin
        chk("stall_prod", product, pp);
        chk("stall_tag", 128'(out_tag), 128'(pt));
        chk("stall_valid", 128'(out_valid), 128'(1));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 128'(in_ready), 128'(0));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("extra_output", 128'(out_tag), 128'(16'hDEAD));
        else begin
          e = q.pop_front();
          chk("product", product, e.p);
          chk("tag", 128'(out_tag), 128'(e.t));
          if (e.lat) chk("latency", 128'(cyc - e.c), 128'(8));
        end
      end
    end
    prev_stall <= reset && out_valid && !out_ready;
    pp <= product;
    pt <= out_tag;
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset && ov32) begin
      if (q32.size() == 0) chk("w32_extra", 128'(ot32), 128'(16'hDEAD));
      else begin
        e = q32.pop_front();
        chk("w32_product", {64'b0, p32}, e.p);
        chk("w32_tag", 128'(ot32), 128'(e.t));
        chk("w32_latency", 128'(cyc - e.c), 128'(4));
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset && ov16) begin
      if (q16.size() == 0) chk("w16_extra", 128'(ot16), 128'(16'hDEAD));
      else begin
        e = q16.pop_front();
        chk("w16_product", {96'b0, p16}, e.p);
        chk("w16_tag", 128'(ot16), 128'(e.t));
        chk("w16_latency", 128'(cyc - e.c), 128'(16));
      end
    end
  end

  initial begin : drv32
    @(posedge clock iff reset);
    #1;
    for (int i = 0; i < 12; i++) begin
      v32 = 1'b1; a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(0, 1)); t32 = 4'(i);
      if (i == 0) begin a32 = 32'h8000_0000; b32 = 32'h8000_0000; s32 = 1'b1; end
      @(negedge clock);
      chk("w32_in_ready", 128'(r32), 128'(1));
      q32.push_back('{mref({32'b0, a32}, {32'b0, b32}, 32, s32), t32, cyc, 1'b1});
      @(posedge clock);
      #1;
    end
    v32 = 1'b0;
    done32 = 1'b1;
  end

  initial begin : drv16
    @(posedge clock iff reset);
    #1;
    for (int i = 0; i < 12; i++) begin
      v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom_range(0, 1)); t16 = 4'(i);
      if (i == 0) begin a16 = 16'hFFFF; b16 = 16'h0003; s16 = 1'b1; end
      @(negedge clock);
      chk("w16_in_ready", 128'(r16), 128'(1));
      q16.push_back('{mref({48'b0, a16}, {48'b0, b16}, 16, s16), t16, cyc, 1'b1});
      @(posedge clock);
      #1;
    end
    v16 = 1'b0;
    done16 = 1'b1;
  end

  initial begin : main
    logic [63:0] a, b;
    logic        s;
    int          g;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_product", product, 128'(0));
    chk("rst_out_tag", 128'(out_tag), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    tick();
    reset = 1'b1;

    // back-to-back unsigned small values
    send(64'd2, 64'd3,   1'b0, 4'd0, 128'd6,   1'b1);
    send(64'd5, 64'd50,  1'b0, 4'd1, 128'd250, 1'b1);
    send(64'd0, 64'd257, 1'b0, 4'd2, 128'd0,   1'b1);
    drain();

    // corner values
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd3,
         128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd4, 128'd1, 1'b1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'd5,
         128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1, 4'd6,
         128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD, 1'b1);
    send(64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 4'd7, 128'd0, 1'b1);
    drain();

    // 16 random ops with a 5-cycle output stall mid-stream
    st_lo = cyc + 10;
    st_hi = st_lo + 5;
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      send(a, b, s, 4'(i), mref(a, b, 64, s), 1'b0);
    end
    drain();

    // reset with 4 ops in flight
    for (int i = 0; i < 4; i++) send(64'(i + 1), 64'd11, 1'b0, 4'(8 + i), 128'(11 * (i + 1)), 1'b0);
    reset = 1'b0;
    tick();
    q.delete();
    @(negedge clock);
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_product", product, 128'(0));
    chk("midrst_out_tag", 128'(out_tag), 128'(0));
    tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    chk("postrst_in_ready", 128'(in_ready), 128'(1));
    chk("postrst_out_valid", 128'(out_valid), 128'(0));
    tick();
    send(64'd7, 64'd9, 1'b0, 4'd9, 128'd63, 1'b1);
    drain();

    g = 0;
    while (!(done32 && done16 && q32.size() == 0 && q16.size() == 0) && g < 200) begin
      tick();
      g++;
    end
    chk("sweep_done", 128'(done32 && done16 && q32.size() == 0 && q16.size() == 0), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
